// File: rtl/anim_pkg.sv
// Shared definitions for the animation frame controller: state codes, plot
// op codes and the default frame-rate divider.
package anim_pkg;

    typedef enum logic [2:0] {
        S_DRAW      = 3'd0,
        S_WAIT      = 3'd1,
        S_ERASE     = 3'd2,
        S_LOAD      = 3'd3,
        S_CHECK     = 3'd4,
        S_GAME_OVER = 3'd5,
        S_INIT      = 3'd6
    } state_e;

    localparam logic [1:0] OP_DRAW  = 2'b00;
    localparam logic [1:0] OP_ERASE = 2'b01;

    // 1/30 s at 50 MHz
    localparam int FRAME_DIV_DEFAULT = 1666667;

    // Counter/index width that never collapses to zero bits.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/anim_frame_ctrl_if.sv
// Controller-to-datapath bus: plot strobes, sprite addressing, coordinate
// pulses and the edge-contact flags coming back.
interface anim_frame_ctrl_if
    import anim_pkg::*;
#(
    parameter int NUM_OBJ = 2,
    parameter int SIZE    = 4
);
    localparam int OBJ_W  = clog2_min1(NUM_OBJ);
    localparam int SIZE_W = clog2_min1(SIZE);

    logic               plot;
    logic [1:0]         op;
    logic [OBJ_W-1:0]   obj_sel;
    logic [SIZE_W-1:0]  dx;
    logic [SIZE_W-1:0]  dy;
    logic               load_coord;
    logic               init_coord;
    logic [NUM_OBJ-1:0] touch_edge;

    modport master (
        output plot, op, obj_sel, dx, dy, load_coord, init_coord,
        input  touch_edge
    );

    modport slave (
        input  plot, op, obj_sel, dx, dy, load_coord, init_coord,
        output touch_edge
    );

endinterface

// File: rtl/anim_frame_ctrl_frame_timer.sv
// Pausable frame-rate wait counter; tick pulses on the last counted cycle.
module frame_timer
    import anim_pkg::*;
#(
    parameter int FRAME_DIV = FRAME_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic pause,
    output logic tick
);
    localparam int CNT_W = clog2_min1(FRAME_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tick = en && !pause && (count_q == LAST);

    // Outside the wait state the count is held at zero so every wait starts fresh.
    always_comb begin
        count_d = count_q;
        if (!en || tick) begin
            count_d = '0;
        end else if (!pause) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/anim_frame_ctrl.sv
// Frame-loop sequencer: draw, wait, erase, move, edge check, with game-over
// and restart. Owns sprite pixel sweep indices but no coordinates.
module anim_frame_ctrl
    import anim_pkg::*;
#(
    parameter int FRAME_DIV = FRAME_DIV_DEFAULT,
    parameter int NUM_OBJ   = 2,
    parameter int SIZE      = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                pause,
    anim_frame_ctrl_if.master   bus,
    output logic                game_over,
    output logic [2:0]          state_dbg
);
    localparam int OBJ_W  = clog2_min1(NUM_OBJ);
    localparam int SIZE_W = clog2_min1(SIZE);
    localparam logic [OBJ_W-1:0]  OBJ_LAST = OBJ_W'(NUM_OBJ - 1);
    localparam logic [SIZE_W-1:0] PIX_LAST = SIZE_W'(SIZE - 1);

    state_e            state_q, state_d;
    logic [OBJ_W-1:0]  obj_q, obj_d;
    logic [SIZE_W-1:0] dx_q, dx_d;
    logic [SIZE_W-1:0] dy_q, dy_d;
    logic              wait_tick;

    frame_timer #(.FRAME_DIV(FRAME_DIV)) u_timer (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == S_WAIT),
        .pause (pause),
        .tick  (wait_tick)
    );

    // Draw and erase share one raster sweep: dx fastest, then dy, then sprite.
    always_comb begin
        state_d = state_q;
        obj_d   = obj_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        case (state_q)
            S_DRAW, S_ERASE: begin
                if (dx_q != PIX_LAST) begin
                    dx_d = dx_q + SIZE_W'(1);
                end else begin
                    dx_d = '0;
                    if (dy_q != PIX_LAST) begin
                        dy_d = dy_q + SIZE_W'(1);
                    end else begin
                        dy_d = '0;
                        if (obj_q != OBJ_LAST) begin
                            obj_d = obj_q + OBJ_W'(1);
                        end else begin
                            obj_d   = '0;
                            state_d = (state_q == S_DRAW) ? S_WAIT : S_LOAD;
                        end
                    end
                end
            end
            S_WAIT:      if (wait_tick) state_d = S_ERASE;
            S_LOAD:      state_d = S_CHECK;
            S_CHECK:     state_d = (|bus.touch_edge) ? S_GAME_OVER : S_DRAW;
            S_GAME_OVER: if (start) state_d = S_INIT;
            S_INIT:      state_d = S_DRAW;
            default: begin
                state_d = S_DRAW;
                obj_d   = '0;
                dx_d    = '0;
                dy_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_DRAW;
            obj_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
        end else begin
            state_q <= state_d;
            obj_q   <= obj_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
        end
    end

    assign bus.plot       = (state_q == S_DRAW) || (state_q == S_ERASE);
    assign bus.op         = (state_q == S_ERASE) ? OP_ERASE : OP_DRAW;
    assign bus.obj_sel    = obj_q;
    assign bus.dx         = dx_q;
    assign bus.dy         = dy_q;
    assign bus.load_coord = (state_q == S_LOAD);
    assign bus.init_coord = (state_q == S_INIT);
    assign game_over      = (state_q == S_GAME_OVER);
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_anim_frame_ctrl.sv
// Self-checking bench for anim_frame_ctrl: a frame-position reference model
// drives per-cycle expectations for a small config, plus a minimal config.
module tb_anim_frame_ctrl;

    localparam int FD = 4;
    localparam int NO = 2;
    localparam int SZ = 2;
    localparam int SS = SZ * SZ;
    localparam int D  = NO * SS;

    typedef struct packed {
        logic       plot;
        logic [1:0] op;
        logic [0:0] obj;
        logic [0:0] dx;
        logic [0:0] dy;
        logic       load;
        logic       init;
        logic       go;
        logic [2:0] st;
    } obs_t;

    logic       clk = 1'b0;
    logic       resetA = 1'b1, startA = 1'b0, pauseA = 1'b0;
    logic       goA;
    logic [2:0] stA;
    logic       resetB = 1'b1, startB = 1'b0, pauseB = 1'b0;
    logic       goB;
    logic [2:0] stB;

    int tests = 0;
    int failures = 0;

    int m_pos = 0;
    bit m_over = 1'b0;
    bit m_init = 1'b0;

    anim_frame_ctrl_if #(.NUM_OBJ(NO), .SIZE(SZ)) ifA ();
    anim_frame_ctrl_if #(.NUM_OBJ(1), .SIZE(1)) ifB ();

    anim_frame_ctrl #(.FRAME_DIV(FD), .NUM_OBJ(NO), .SIZE(SZ)) dutA (
        .clk       (clk),
        .reset     (resetA),
        .start     (startA),
        .pause     (pauseA),
        .bus       (ifA),
        .game_over (goA),
        .state_dbg (stA)
    );

    anim_frame_ctrl #(.FRAME_DIV(1), .NUM_OBJ(1), .SIZE(1)) dutB (
        .clk       (clk),
        .reset     (resetB),
        .start     (startB),
        .pause     (pauseB),
        .bus       (ifB),
        .game_over (goB),
        .state_dbg (stB)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic obs_t sample_a();
        obs_t s;
        s.plot = ifA.plot;
        s.op   = ifA.op;
        s.obj  = ifA.obj_sel;
        s.dx   = ifA.dx;
        s.dy   = ifA.dy;
        s.load = ifA.load_coord;
        s.init = ifA.init_coord;
        s.go   = goA;
        s.st   = stA;
        return s;
    endfunction

    // Expected outputs from the position within the frame timeline.
    function automatic obs_t model_out();
        obs_t e;
        int   p;
        e = '0;
        if (m_over) begin
            e.go = 1'b1; e.st = 3'd5;
        end else if (m_init) begin
            e.init = 1'b1; e.st = 3'd6;
        end else if (m_pos < D) begin
            p = m_pos;
            e.plot = 1'b1; e.op = 2'b00; e.st = 3'd0;
            e.obj = 1'(p / SS); e.dx = 1'((p % SS) % SZ); e.dy = 1'((p % SS) / SZ);
        end else if (m_pos < D + FD) begin
            e.st = 3'd1;
        end else if (m_pos < 2 * D + FD) begin
            p = m_pos - D - FD;
            e.plot = 1'b1; e.op = 2'b01; e.st = 3'd2;
            e.obj = 1'(p / SS); e.dx = 1'((p % SS) % SZ); e.dy = 1'((p % SS) / SZ);
        end else if (m_pos == 2 * D + FD) begin
            e.load = 1'b1; e.st = 3'd3;
        end else begin
            e.st = 3'd4;
        end
        return e;
    endfunction

    task automatic model_step(input bit p, input bit s, input logic [1:0] te);
        if (m_over) begin
            if (s) begin m_over = 1'b0; m_init = 1'b1; end
        end else if (m_init) begin
            m_init = 1'b0; m_pos = 0;
        end else if (m_pos == 2 * D + FD + 1) begin
            if (te != 2'b00) m_over = 1'b1;
            m_pos = 0;
        end else if (!(p && m_pos >= D && m_pos < D + FD)) begin
            m_pos++;
        end
    endtask

    task automatic apply_reset_a();
        startA = 1'b0; pauseA = 1'b0; ifA.touch_edge = 2'b00;
        resetA = 1'b1;
        m_pos = 0; m_over = 1'b0; m_init = 1'b0;
        tick();
        resetA = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        apply_reset_a();
        got = sample_a(); exp = model_out();
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL reset_state got=%h want=%h", got, exp);
        end
        tests++;
        if (got.plot !== 1'b1 || got.st !== 3'd0) begin
            failures++;
            $display("[TB] FAIL reset_plot got plot=%b st=%0d want plot=1 st=0", got.plot, got.st);
        end
    endtask

    task automatic test_frame_sequence();
        obs_t got, exp;
        int   loadAt = -1;
        apply_reset_a();
        for (int c = 0; c < 2 * (2 * D + FD + 2); c++) begin
            got = sample_a(); exp = model_out();
            tests++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL frame c=%0d got=%h want=%h", c, got, exp);
            end
            if (got.load && loadAt < 0) loadAt = c;
            model_step(1'b0, 1'b0, 2'b00);
            tick();
        end
        tests++;
        if (loadAt !== 20) begin
            failures++;
            $display("[TB] FAIL load_cycle got=%0d want=20", loadAt);
        end
    endtask

    task automatic test_pause();
        obs_t got, exp;
        int   period = -1;
        bit   seenCheck = 1'b0;
        apply_reset_a();
        for (int c = 0; c < 30; c++) begin
            got = sample_a(); exp = model_out();
            tests++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL pause c=%0d got=%h want=%h", c, got, exp);
            end
            if (got.st == 3'd4) seenCheck = 1'b1;
            else if (seenCheck && got.st == 3'd0 && period < 0) period = c;
            pauseA = (c >= D + 1 && c < D + 4);
            model_step(pauseA, 1'b0, 2'b00);
            tick();
        end
        pauseA = 1'b0;
        tests++;
        if (period !== 25) begin
            failures++;
            $display("[TB] FAIL pause_period got=%0d want=25", period);
        end
    endtask

    task automatic test_inputs_ignored();
        obs_t got, exp;
        apply_reset_a();
        startA = 1'b1;
        for (int c = 0; c < 2 * (2 * D + FD + 2); c++) begin
            got = sample_a(); exp = model_out();
            tests++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL ignored c=%0d got=%h want=%h", c, got, exp);
            end
            pauseA = (m_pos < D);
            model_step(pauseA, startA, 2'b00);
            tick();
        end
        startA = 1'b0; pauseA = 1'b0;
    endtask

    task automatic test_game_over();
        obs_t got, exp;
        int   goCount = 0, initCount = 0;
        apply_reset_a();
        for (int c = 0; c < 38; c++) begin
            got = sample_a(); exp = model_out();
            tests++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL gameover c=%0d got=%h want=%h", c, got, exp);
            end
            if (got.go) goCount++;
            if (got.init) initCount++;
            ifA.touch_edge = (c < 22) ? 2'b10 : 2'b00;
            startA = (c == 32);
            model_step(1'b0, startA, ifA.touch_edge);
            tick();
        end
        startA = 1'b0;
        tests++;
        if (goCount !== 11 || initCount !== 1) begin
            failures++;
            $display("[TB] FAIL gameover_counts got go=%0d init=%0d want go=11 init=1", goCount, initCount);
        end
    endtask

    task automatic test_reset_mid_erase();
        obs_t got, exp;
        apply_reset_a();
        for (int c = 0; c <= D + FD + 2; c++) begin
            got = sample_a(); exp = model_out();
            tests++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL mid_erase c=%0d got=%h want=%h", c, got, exp);
            end
            if (c < D + FD + 2) begin
                model_step(1'b0, 1'b0, 2'b00);
                tick();
            end
        end
        resetA = 1'b1;
        tick();
        resetA = 1'b0;
        m_pos = 0; m_over = 1'b0; m_init = 1'b0;
        got = sample_a();
        tests++;
        if (got.st !== 3'd0 || got.obj !== 1'b0 || got.dx !== 1'b0 || got.dy !== 1'b0 ||
            got.plot !== 1'b1 || got.op !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_abort got=%h want st=0 obj/dx/dy=0 plot=1 op=0", got);
        end
    endtask

    task automatic test_random();
        obs_t got, exp;
        apply_reset_a();
        for (int c = 0; c < 400; c++) begin
            got = sample_a(); exp = model_out();
            tests++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL random c=%0d got=%h want=%h", c, got, exp);
            end
            pauseA = ($urandom_range(0, 2) == 0);
            startA = ($urandom_range(0, 5) == 0);
            ifA.touch_edge = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            model_step(pauseA, startA, ifA.touch_edge);
            tick();
        end
        pauseA = 1'b0; startA = 1'b0; ifA.touch_edge = 2'b00;
    endtask

    task automatic test_min_config();
        logic [4:0] plotPat;
        logic [2:0] stPat [5];
        plotPat = 5'b00101;
        stPat = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        ifB.touch_edge = 1'b0;
        resetB = 1'b1;
        tick();
        resetB = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tests++;
            if (ifB.plot !== plotPat[c % 5] || stB !== stPat[c % 5]) begin
                failures++;
                $display("[TB] FAIL min_cfg c=%0d got plot=%b st=%0d want plot=%b st=%0d",
                         c, ifB.plot, stB, plotPat[c % 5], stPat[c % 5]);
            end
            tick();
        end
    endtask

    initial begin
        ifA.touch_edge = 2'b00;
        ifB.touch_edge = 1'b0;
        @(negedge clk);
        test_reset();
        test_frame_sequence();
        test_pause();
        test_inputs_ignored();
        test_game_over();
        test_reset_mid_erase();
        test_random();
        test_min_config();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/anim_frame_ctrl.md
Name: anim_frame_ctrl

Overview:
Parametrised frame-sequencing controller for the VGA game engine. It drives NUM_OBJ square sprites through the frame loop draw → wait → erase → move → edge check. It generates per-pixel plot strobes with sprite-relative offsets and a frame-rate wait timer with pause. Game over is detected from per-object edge flags, and a restart path is provided. The controller sits between the top level and the coordinate/VGA datapath; it owns no coordinates itself.

Parameters:
FRAME_DIV, 1666667, wait length in clk cycles (1/30 s at 50 MHz); must be ≥1
NUM_OBJ, 2, number of sprites sequenced per frame; must be ≥1
SIZE, 4, sprite side in pixels, giving SIZE*SIZE plot cycles per sprite; must be ≥1
OBJ_W, max(1,clog2(NUM_OBJ)), derived
SIZE_W, max(1,clog2(SIZE)), derived

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  leaves S_GAME_OVER; ignored in every other state
pause  in  1  holds the wait timer while high; ignored outside S_WAIT
touch_edge  in  NUM_OBJ  per-object edge-contact flag from the datapath
plot  out  1  pixel write strobe to the VGA adapter
op  out  2  00 draw colour, 01 erase (background colour); 00 when idle
obj_sel  out  OBJ_W  sprite currently addressed
dx  out  SIZE_W  column offset within the sprite
dy  out  SIZE_W  row offset within the sprite
load_coord  out  1  one-cycle pulse: datapath advances all coordinates
init_coord  out  1  one-cycle pulse: datapath restores start coordinates
game_over  out  1  high throughout S_GAME_OVER
state_dbg  out  3  current state encoding, for LEDs

Behaviour:
- All outputs are Moore outputs, decoded combinationally from registered state and counters.
- Reset (sync, high):
  - state=S_DRAW; obj_sel, dx, dy and the wait counter are cleared to 0.
  - All other outputs read 0 except plot=1 and op=00 (S_DRAW decode).
  - Reset in any state, mid-sprite or mid-wait, aborts immediately; no partial frame completion.
- S_DRAW:
  - plot=1, op=00 every cycle.
  - dx increments each cycle. At dx=SIZE-1, dx wraps to 0 and dy increments.
  - At dx=dy=SIZE-1: if obj_sel<NUM_OBJ-1, obj_sel increments and dx/dy clear; otherwise obj_sel/dx/dy clear and the state goes to S_WAIT.
  - Duration is exactly NUM_OBJ*SIZE*SIZE cycles.
- S_WAIT:
  - plot=0.
  - The counter increments each cycle in which pause=0.
  - When counter==FRAME_DIV-1 and pause=0, the counter clears and the state goes to S_ERASE. FRAME_DIV=1 gives exactly one wait cycle.
  - pause=1 freezes the counter with no loss of count.
- S_ERASE: identical sequencing to S_DRAW with op=01; exits to S_LOAD.
- S_LOAD: load_coord=1 for one cycle, then S_CHECK.
- S_CHECK:
  - One cycle; samples touch_edge (the post-move values).
  - |touch_edge → S_GAME_OVER; otherwise → S_DRAW.
- S_GAME_OVER:
  - game_over=1, plot=0; holds until start=1.
  - On start, go to S_INIT.
  - The last frame's sprites remain erased on screen.
- S_INIT: init_coord=1 for one cycle, then S_DRAW. The wait counter is cleared.
- Frame period without pause: 2*NUM_OBJ*SIZE*SIZE + FRAME_DIV + 2 cycles.
- Wait counter width: clog2(FRAME_DIV), minimum 1 bit. No other counter is ever allowed to exceed its terminal value.
- State encoding: DRAW=0, WAIT=1, ERASE=2, LOAD=3, CHECK=4, GAME_OVER=5, INIT=6. Code 7 is illegal and recovers to S_DRAW on the next clock.

Decomposition:
- Shared package anim_pkg holds:
  - state encodings (3-bit)
  - op codes OP_DRAW=2'b00 and OP_ERASE=2'b01
  - the default FRAME_DIV constant
- One natural sub-module, frame_timer, contains the pausable wait counter. Its ports are clk, reset, en, pause and tick (a single-cycle pulse at terminal count).
- The sprite pixel sweep (dx/dy/obj_sel) stays in the top FSM.

Test Plan:
1. FRAME_DIV=4, NUM_OBJ=2, SIZE=2, pause=0, touch_edge=0, release reset → plot high 8 cycles (obj_sel 0,0,0,0,1,1,1,1; dx/dy 0/0,1/0,0/1,1/1 repeated), 4 idle cycles, 8 erase cycles op=01, load_coord at cycle 21; frame period 22.
2. Same config, pause=1 for 3 cycles during S_WAIT → S_ERASE entry delayed by exactly 3 cycles; frame period 25.
3. touch_edge=2'b10 asserted before S_CHECK → game_over=1 from the next cycle and stays high for 10 cycles of start=0; on start=1, init_coord pulses once, then S_DRAW with obj_sel=0.
4. start=1 held throughout normal frames, and pause=1 throughout S_DRAW → no effect on sequence or timing versus scenario 1.
5. reset=1 for one cycle at the 3rd cycle of S_ERASE → next cycle state_dbg=0, obj_sel=dx=dy=0, plot=1, op=00.
6. FRAME_DIV=1, NUM_OBJ=1, SIZE=1 → per frame: 1 draw, 1 wait, 1 erase, load, check; period 5 cycles, plot pattern 1,0,1,0,0.
